// File: rtl/mem_types_pkg.sv
// rtl/mem_types_pkg.sv - shared memory-port types, idle control word and arbiter state encoding
package mem_types;

    localparam int XLEN     = 32;
    // Wide enough for up to 8 masters.
    localparam int REQ_ID_W = 3;

    typedef logic [REQ_ID_W-1:0] req_id_t;

    typedef struct packed {
        logic            we;
        logic            re;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } mem_control_t;

    // No write and no read, so the memory sees no side effects.
    localparam mem_control_t MEM_CTRL_IDLE = '0;

    typedef enum logic {
        ARB_IDLE,
        ARB_OWNED
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set mask bit after `from`, wrapping
//
// Ports:
//   mask   in   NUM_REQ    candidate requesters
//   from   in   req_id_t   search starts at from+1
//   found  out  1          mask had a set bit
//   id     out  req_id_t   chosen requester (0 when nothing found)
module rr_pick
    import mem_types::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] mask,
    input  req_id_t            from,
    output logic               found,
    output req_id_t            id
);

    // Doubling the mask and shifting by from+1 puts the search order at bit 0 upward,
    // so the wrap-around becomes a plain ascending scan with constant indices.
    logic [2*NUM_REQ-1:0] doubled;
    logic [2*NUM_REQ-1:0] rotated;

    assign doubled = {mask, mask};
    assign rotated = doubled >> (int'(from) + 1);

    always_comb begin
        found = 1'b0;
        id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && rotated[k]) begin
                found = 1'b1;
                id    = req_id_t'((int'(from) + 1 + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port with bounded burst lock
//
// Ports:
//   clock      in   1                      system clock
//   reset      in   1                      synchronous, active-high
//   req_valid  in   NUM_REQ                master i wants the port
//   req_ctrl   in   mem_control_t[NUM_REQ] access presented by master i
//   grant      out  NUM_REQ                one-hot owner, zero when idle
//   mem_ctrl   out  mem_control_t          to memory, MEM_CTRL_IDLE when nothing issues
//   mem_rdata  in   XLEN                   from memory
//   rsp_valid  out  NUM_REQ                one-hot completion strobe, READ_LATENCY after issue
//   rsp_rdata  out  XLEN                   mem_rdata broadcast
module mem_port_arbiter
    import mem_types::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int READ_LATENCY = 1,
    parameter int MAX_BURST    = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic         [NUM_REQ-1:0] req_valid,
    input  mem_control_t [NUM_REQ-1:0] req_ctrl,
    output logic         [NUM_REQ-1:0] grant,
    output mem_control_t               mem_ctrl,
    input  logic         [XLEN-1:0]    mem_rdata,
    output logic         [NUM_REQ-1:0] rsp_valid,
    output logic         [XLEN-1:0]    rsp_rdata
);

    localparam int            BW        = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

    arb_state_t          state_q, state_d;
    req_id_t             owner_q, owner_d;
    req_id_t             last_owner_q, last_owner_d;
    logic [BW-1:0]       burst_cnt_q, burst_cnt_d, burst_inc;
    logic [NUM_REQ-1:0]  owner_oh, pending, pick_mask;
    req_id_t             pick_from, pick_id;
    logic                pick_found, issue, owner_req, limit_hit;

    logic [READ_LATENCY-1:0] pipe_valid;
    req_id_t                 pipe_id [READ_LATENCY];

    // grant comes from registered state only; req_valid never reaches it combinationally.
    assign owner_oh  = NUM_REQ'(1) << owner_q;
    assign grant     = (state_q == ARB_OWNED) ? owner_oh : '0;
    assign owner_req = |(owner_oh & req_valid);
    assign issue     = |(grant & req_valid);
    assign pending   = req_valid & ~owner_oh;

    always_comb begin
        mem_ctrl = MEM_CTRL_IDLE;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i] && req_valid[i]) begin
                mem_ctrl = req_ctrl[i];
            end
        end
    end

    // From IDLE the search resumes after the last owner; while owned it resumes after
    // the current owner and skips it.
    assign pick_mask = (state_q == ARB_IDLE) ? req_valid : pending;
    assign pick_from = (state_q == ARB_IDLE) ? last_owner_q : owner_q;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .mask  (pick_mask),
        .from  (pick_from),
        .found (pick_found),
        .id    (pick_id)
    );

    // Saturating count of issue cycles in the current tenure. With MAX_BURST = 0 the
    // ceiling is 0, so it never moves and limit_hit is never raised.
    assign burst_inc = (issue && (burst_cnt_q != BURST_MAX)) ? burst_cnt_q + 1'b1 : burst_cnt_q;
    assign limit_hit = (MAX_BURST != 0) && (burst_inc == BURST_MAX);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_inc;
        case (state_q)
            ARB_IDLE: begin
                burst_cnt_d = '0;
                if (pick_found) begin
                    state_d = ARB_OWNED;
                    owner_d = pick_id;
                end
            end
            ARB_OWNED: begin
                if (!owner_req) begin
                    last_owner_d = owner_q;
                    burst_cnt_d  = '0;
                    if (pick_found) begin
                        owner_d = pick_id;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end else if (limit_hit && pick_found) begin
                    // Preempted owner keeps req_valid high and re-queues behind the others.
                    last_owner_d = owner_q;
                    owner_d      = pick_id;
                    burst_cnt_d  = '0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            owner_q      <= '0;
            last_owner_q <= req_id_t'(NUM_REQ - 1);
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    // Responses follow the id that issued, not whoever owns the port when data returns.
    // Reset flushes the pipe so in-flight accesses never complete.
    always_ff @(posedge clock) begin
        if (reset) begin
            pipe_valid <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_id[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= issue;
            pipe_id[0]    <= owner_q;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_id[i]    <= pipe_id[i-1];
            end
        end
    end

    assign rsp_valid = pipe_valid[READ_LATENCY-1] ? (NUM_REQ'(1) << pipe_id[READ_LATENCY-1]) : '0;
    assign rsp_rdata = mem_rdata;

endmodule
